// File: rtl/regfile_pkg.sv
// Shared constants and types for the Decode-stage register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bundle for the register file: operand reads, writeback, issue reservation.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     flush;
  logic [AW:0]              busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_sb_bypass.sv
// Per-read-port selector between stored data and the winning same-edge write.
module regfile_sb_bypass
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic [AW-1:0]            rd_addr,
  input  logic [XLEN-1:0]          stored,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  output logic [XLEN-1:0]          rd_next,
  output logic                     hit
);

  // Ascending scan so the highest-index matching port overrides, like the array write.
  always_comb begin
    hit     = 1'b0;
    rd_next = stored;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w] == rd_addr)) begin
        hit     = 1'b1;
        rd_next = wr_data[w];
      end
    end
    if (rd_addr == AW'(ZERO_REG)) begin
      rd_next = '0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with registered reads, write bypass and pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  logic [XLEN-1:0]          mem [NREGS];
  logic [NREGS-1:0]         busy;
  logic [NREGS-1:0]         busy_next;
  logic [AW:0]              cnt_q;
  logic [AW:0]              cnt_next;
  logic [NRD-1:0][XLEN-1:0] rd_q;
  logic [NRD-1:0][XLEN-1:0] rd_next;
  logic [NRD-1:0]           rd_hit;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_sb_bypass #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NWR   (NWR)
    ) u_bypass (
      .rd_addr (bus.rd_addr[p]),
      .stored  (mem[bus.rd_addr[p]]),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_next (rd_next[p]),
      .hit     (rd_hit[p])
    );
  end

  // Later ports are written last, so they win on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w] != AW'(ZERO_REG))) begin
          mem[bus.wr_addr[w]] <= bus.wr_data[w];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_next;
    end
  end

  // Flush and writeback clears apply first; a new reservation is the youngest producer and wins.
  always_comb begin
    busy_next = busy;
    if (bus.flush) begin
      busy_next = '0;
    end
    for (int w = 0; w < NWR; w++) begin
      if (bus.wr_en[w]) begin
        busy_next[bus.wr_addr[w]] = 1'b0;
      end
    end
    if (bus.iss_en) begin
      busy_next[bus.iss_addr] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_next;
      cnt_q <= cnt_next;
    end
  end

  // A same-cycle write resolves the hazard through the bypass, so it masks the busy bit.
  always_comb begin
    bus.rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      bus.rd_busy[p] = busy[bus.rd_addr[p]] & ~rd_hit[p];
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed vectors queue expectations, a monitor checks reads.
module tb_regfile_sb;
  import regfile_pkg::*;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [5:0]  cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic sample_req;
  logic exp_vld;
  int   checks;
  int   errors;
  exp_t expq[$];
  exp_t mon_e;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reads issued before an edge are checked on the following falling edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) exp_vld <= 1'b0;
    else      exp_vld <= sample_req;
  end

  always @(negedge clk) begin
    if (exp_vld) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty got 0 expected 1");
      end else begin
        mon_e = expq.pop_front();
        check_output("rd_data0", bus.rd_data[0], mon_e.d0);
        check_output("rd_data1", bus.rd_data[1], mon_e.d1);
        check_output("busy_cnt", 32'(bus.busy_cnt), 32'(mon_e.cnt));
      end
    end
  end

  task automatic wr(input int port, input logic [4:0] addr, input logic [31:0] data);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = addr;
    bus.wr_data[port] = data;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr[0] = a0;
    bus.rd_addr[1] = a1;
  endtask

  task automatic iss(input logic [4:0] addr);
    bus.iss_en   = 1'b1;
    bus.iss_addr = addr;
  endtask

  task automatic apply_stimulus(input logic [31:0] e0, input logic [31:0] e1, input logic [5:0] ecnt);
    expq.push_back('{d0: e0, d1: e1, cnt: ecnt});
    sample_req = 1'b1;
    @(negedge clk);
    sample_req  = 1'b0;
    bus.wr_en   = '0;
    bus.iss_en  = 1'b0;
    bus.flush   = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    sample_req   = 1'b0;
    rst          = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.flush    = 1'b0;

    repeat (2) @(negedge clk);
    check_output("reset_rd_data0", bus.rd_data[0], 32'h0);
    check_output("reset_busy_cnt", 32'(bus.busy_cnt), 32'h0);
    rst = 1'b1;

    wr(0, 5'd3, 32'h5); rd(5'd3, 5'd0);
    apply_stimulus(32'h5, 32'h0, 6'd0);
    rd(5'd3, 5'd0);
    apply_stimulus(32'h5, 32'h0, 6'd0);
    wr(0, 5'd0, 32'hFF); rd(5'd0, 5'd3);
    apply_stimulus(32'h0, 32'h5, 6'd0);
    rd(5'd0, 5'd3);
    apply_stimulus(32'h0, 32'h5, 6'd0);

    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(5'd7, 5'd7);
    apply_stimulus(32'h22, 32'h22, 6'd0);
    rd(5'd7, 5'd3);
    apply_stimulus(32'h22, 32'h5, 6'd0);

    iss(5'd9); rd(5'd9, 5'd3);
    #1 check_output("rd_busy_before_issue", 32'(bus.rd_busy[0]), 32'h0);
    apply_stimulus(32'h0, 32'h5, 6'd1);
    rd(5'd9, 5'd3);
    #1 check_output("rd_busy_r9", 32'(bus.rd_busy[0]), 32'h1);
    apply_stimulus(32'h0, 32'h5, 6'd1);
    wr(1, 5'd9, 32'h40); rd(5'd9, 5'd9);
    #1 check_output("rd_busy_r9_bypass0", 32'(bus.rd_busy[0]), 32'h0);
    check_output("rd_busy_r9_bypass1", 32'(bus.rd_busy[1]), 32'h0);
    apply_stimulus(32'h40, 32'h40, 6'd0);

    iss(5'd4); rd(5'd4, 5'd9);
    apply_stimulus(32'h0, 32'h40, 6'd1);
    iss(5'd4); wr(0, 5'd4, 32'h77); rd(5'd4, 5'd9);
    #1 check_output("rd_busy_collide", 32'(bus.rd_busy[0]), 32'h0);
    apply_stimulus(32'h77, 32'h40, 6'd1);
    rd(5'd4, 5'd9);
    #1 check_output("rd_busy_r4_kept", 32'(bus.rd_busy[0]), 32'h1);
    apply_stimulus(32'h77, 32'h40, 6'd1);

    iss(5'd1);
    apply_stimulus(32'h77, 32'h40, 6'd2);
    iss(5'd2);
    apply_stimulus(32'h77, 32'h40, 6'd3);
    iss(5'd31);
    apply_stimulus(32'h77, 32'h40, 6'd4);
    bus.flush = 1'b1; iss(5'd6); rd(5'd6, 5'd31);
    apply_stimulus(32'h0, 32'h0, 6'd1);
    rd(5'd6, 5'd4);
    #1 check_output("rd_busy_r6", 32'(bus.rd_busy[0]), 32'h1);
    check_output("rd_busy_r4_flushed", 32'(bus.rd_busy[1]), 32'h0);
    apply_stimulus(32'h0, 32'h77, 6'd1);

    wr(0, 5'd5, 32'hDEAD); rd(5'd5, 5'd4);
    #2 rst = 1'b0;
    #1 check_output("async_rst_rd_data0", bus.rd_data[0], 32'h0);
    check_output("async_rst_rd_data1", bus.rd_data[1], 32'h0);
    check_output("async_rst_busy_cnt", 32'(bus.busy_cnt), 32'h0);
    @(negedge clk);
    rst       = 1'b1;
    bus.wr_en = '0;
    rd(5'd5, 5'd6);
    #1 check_output("rd_busy_after_rst", 32'(bus.rd_busy[1]), 32'h0);
    apply_stimulus(32'h0, 32'h0, 6'd0);

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d expected 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with registered read ports, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits in the Decode stage and replaces the fixed 2-read/1-write file. Operand reads, writeback from one or more retire paths, and destination reservation at issue all meet here, so Decode can detect RAW hazards without scanning the pipeline registers.

## Interface
- XLEN, 32, data width
- NREGS, 32, register count (power of two, ≥ 2); register 0 is hardwired zero
- NRD, 2, read ports
- NWR, 1, write ports
- AW, $clog2(NREGS), derived address width; not overridable

- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NRD×AW  read address per port
- rd_data  out  NRD×XLEN  registered read data per port
- rd_busy  out  NRD  combinational: the addressed register has a pending write that is not resolved this cycle
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR×AW  write address per port
- wr_data  in  NWR×XLEN  write data per port
- iss_en  in  1  reserve a destination register
- iss_addr  in  AW  destination being reserved
- flush  in  1  clear all reservations
- busy_cnt  out  AW+1  number of reserved registers

## Operation
- **Storage.** NREGS×XLEN array; entry 0 is never written and always reads 0.
- **Write.** On the rising edge, for each port with wr_en=1 and wr_addr≠0, the entry takes wr_data.
  - If several ports target the same address, the highest-index port wins.
- **Read.** On the rising edge, rd_data[p] loads the entry at rd_addr[p].
  - Bypass: if any port writes rd_addr[p] on the same edge, rd_data[p] loads that write's data, chosen with the same priority as the write.
  - rd_addr[p]=0 always loads 0.
- **Scoreboard.** One busy bit per register; bit 0 is constant 0.
  - Set: iss_en=1 and iss_addr≠0 sets busy[iss_addr].
  - Clear: any wr_en=1 with wr_addr=a clears busy[a].
  - Set and clear on the same register in the same edge: the set wins, because the new producer is younger.
  - flush=1 clears every bit. A simultaneous iss_en is still applied, so the flush and the new reservation happen together.
- **rd_busy[p].** Equals busy[rd_addr[p]] AND NOT (a write to rd_addr[p] in the current cycle). The bypass covers that case, so Decode need not stall on it.
- **busy_cnt.** Population count of the busy bits, registered and updated on the same edge as the bits. It never exceeds NREGS−1.
- **Reset (rst=0).** Takes effect immediately, independent of clk:
  - all entries = 0
  - all busy bits = 0
  - every rd_data = 0
  - busy_cnt = 0
  - Reset asserted during a write or issue discards that operation. Writes and issues are accepted again from the first rising edge after rst deasserts.

## Timing
- Read latency: 1 cycle. rd_data reflects rd_addr sampled at the previous edge, including same-edge writes.
- Write-to-read: a write on edge N is visible on the edge-N read (bypass) and on every later read.
- rd_busy: zero latency from rd_addr, wr_en, wr_addr. It has no combinational path from iss_en or flush.
- A reservation at edge N is seen by rd_busy from cycle N+1.
- busy_cnt matches the busy bits with no extra delay.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN and NREGS constants
  - the ZERO_REG localparam (0)
  - typedef reg_addr_t for the AW-bit address
  - typedef xword_t for the XLEN-bit word
- One natural sub-module: regfile_sb_bypass, one instance per read port. It selects between stored data and the highest-priority same-edge write for that port's address.
- The scoreboard stays inline.

## Test plan
- **Reset.** rst=0 mid-cycle while wr_en=1, wr_addr=5, wr_data=0xDEAD → rd_data and busy_cnt are 0 immediately. After release, reading r5 returns 0.
- **Write/read and x0.**
  - Write r3=0x5, then read r3 and r0 → 0x5 and 0.
  - Write r0=0xFF → r0 still reads 0 and busy[0] stays 0.
- **Bypass and priority (NWR=2).**
  - Same edge: port0 writes r7=0x11, port1 writes r7=0x22, port0 reads r7 → rd_data=0x22.
  - r7 reads 0x22 from then on.
- **Scoreboard hazard.**
  - Issue r9 → rd_busy for r9 is 1 from the next cycle; busy_cnt=1.
  - Write r9=0x40 → rd_busy is 0 in that same cycle and busy_cnt=0 after the edge.
- **Set/clear collision.** iss_en r4 and wr_en r4 on the same edge, with r4 already busy → r4 remains busy, busy_cnt unchanged, data updated.
- **Flush.** Reserve r1, r2 and r31, then flush=1 together with iss_en r6 → only r6 busy, busy_cnt=1.
